switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Input-side counterpart to the display path: takes the raw asynchronous DIP-switch word and turns it into a clean, synchronized word plus a change event.
- Synchronizes the word, requires it to be stable for a programmable number of cycles, then commits it.
- Raises a valid/ack event carrying the new word and a mask of the bits that changed.
- Sits between the board switch pins and any consumer logic (counter preload, mode select) in the fast clock domain.

Parameters:
- WIDTH, 6, width of the switch word.
- STABLE_CYCLES, 500000, consecutive identical synchronized samples required before commit (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 20, stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- i_clk  in  1  single clock; all state is on the rising edge.
- i_ar  in  1  reset, asynchronous, active-high. Asserting it clears all state immediately, regardless of clock.
- i_switches  in  WIDTH  raw asynchronous switch inputs.
- i_ack  in  1  consumer acknowledge; meaningful only while o_valid=1.
- o_word  out  WIDTH  last committed debounced word.
- o_valid  out  1  a committed change is pending.
- o_changed  out  WIDTH  bits of o_word that changed since the last acknowledged event.
- o_overrun  out  1  a commit happened while a previous event was still unacknowledged.

Behaviour:
- Reset value for all outputs and internal state is 0: sync stages, candidate, counter, o_word, o_valid, o_changed, o_overrun.
- Synchronizer: two flip-flop stages per bit, s1 then s2. No logic between the stages.
- Candidate tracking, evaluated every cycle:
  - If s2 != candidate: candidate <= s2 and cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Otherwise cnt saturates at STABLE_CYCLES-1 and does not wrap.
- Commit condition: s2 == candidate, cnt == STABLE_CYCLES-1, and candidate != o_word.
- On commit:
  - o_word <= candidate, registered; it changes only on a commit.
  - o_valid <= 1.
- o_changed on commit:
  - If o_valid=0, or i_ack=1 in the same cycle: o_changed <= candidate ^ o_word.
  - If o_valid=1 and i_ack=0: o_changed <= o_changed | (candidate ^ o_word), and o_overrun <= 1.
- Acknowledge without a commit: when o_valid & i_ack, clear o_valid, o_changed and o_overrun next cycle.
- Simultaneous ack and commit: o_valid stays 1, o_changed holds only the new mask, o_overrun <= 0.
- i_ack while o_valid=0 is ignored.
- Latency: if an input change is first captured into s1 at edge E and held, o_valid and the new o_word appear after edge E+STABLE_CYCLES+2.
- Glitch rejection: any s2 change shorter than STABLE_CYCLES cycles restarts the counter and produces no event.
- Bounce that settles back to the committed value produces no event, because candidate == o_word.
- No multi-bit coherence is assumed across the synchronizer; the stability window absorbs bit skew.
- Reset asserted mid-count or with an event pending: all state clears. After reset is released, a nonzero switch word produces a normal event after the full latency.

Decomposition:
- Shared package: default WIDTH, STABLE_CYCLES and CNT_W constants, plus the simulation override value SIM_STABLE_CYCLES=8.
- One sub-module: sync_2ff (parameterized WIDTH, async active-high reset to 0), reusable for i_ar-domain crossings elsewhere.

Test Plan (STABLE_CYCLES=8):
- Reset: i_ar pulsed mid-simulation -> all outputs 0 asynchronously; with i_switches held 0 afterwards, no o_valid.
- Clean change: i_switches 00->05 held, first captured at edge E -> o_valid=1, o_word=05, o_changed=05 after edge E+10. Pulse i_ack -> o_valid=0, o_changed=0 next cycle.
- Glitch: i_switches 00->01 for 5 cycles, then back to 00 -> no o_valid, o_word stays 00. A 7-cycle pulse also produces no event; a 9-cycle pulse produces one.
- Overrun: commit 05 with no ack, then switches ->07 stable -> o_word=07, o_changed=07, o_overrun=1. Ack -> all three flags clear.
- Simultaneous: i_ack asserted on the exact commit edge of 05->04 -> o_valid stays 1, o_changed=01, o_overrun=0.
- Bounce back: with o_word=04, switches toggle 04/06 every 3 cycles then settle at 04 -> no event; cnt reaches 7 and holds.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the switch debouncer.
package switch_debounce_pkg;

    localparam int DEF_WIDTH         = 6;
    localparam int DEF_STABLE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEF_CNT_W         = 20;
    localparam int SIM_STABLE_CYCLES = 8;       // short window for simulation

    // What the event register does in a given cycle
    typedef enum logic [1:0] {
        EV_NONE,   // hold
        EV_NEW,    // commit into an idle (or just acknowledged) event slot
        EV_MERGE,  // commit on top of an unacknowledged event
        EV_ACK     // consumer acknowledged, no commit this cycle
    } event_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch word in, debounced word and change event out.
interface switch_debounce_if
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] i_switches;
    logic             i_ack;
    logic [WIDTH-1:0] o_word;
    logic             o_valid;
    logic [WIDTH-1:0] o_changed;
    logic             o_overrun;

    // Debouncer side
    modport slave (
        input  i_switches,
        input  i_ack,
        output o_word,
        output o_valid,
        output o_changed,
        output o_overrun
    );

    // Board pins plus consumer side
    modport master (
        output i_switches,
        output i_ack,
        input  o_word,
        input  o_valid,
        input  o_changed,
        input  o_overrun
    );

endinterface

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // Two back-to-back flops with nothing in between to give metastability time to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces the DIP-switch word and raises a change event with a bit mask.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_ar,
    switch_debounce_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic [WIDTH-1:0] changed_q;
    logic             overrun_q;
    logic             commit;
    logic [WIDTH-1:0] diff;
    event_t           ev;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (i_clk),
        .rst (i_ar),
        .d   (bus.i_switches),
        .q   (s2)
    );

    // Track the most recent synchronized value and how long it has been stable
    always_ff @(posedge i_clk or posedge i_ar) begin
        if (i_ar) begin
            candidate <= '0;
            cnt       <= '0;
        end else if (s2 != candidate) begin
            candidate <= s2;
            cnt       <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign commit = (s2 == candidate) && (cnt == CNT_MAX) && (candidate != word_q);
    assign diff   = candidate ^ word_q;

    // Decide how the event register reacts to commit and acknowledge this cycle
    always_comb begin
        ev = EV_NONE;
        if (commit) begin
            if (!valid_q || bus.i_ack) begin
                ev = EV_NEW;
            end else begin
                ev = EV_MERGE;
            end
        end else if (valid_q && bus.i_ack) begin
            ev = EV_ACK;
        end
    end

    // Committed word and the pending change event
    always_ff @(posedge i_clk or posedge i_ar) begin
        if (i_ar) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (ev)
                EV_NEW: begin
                    word_q    <= candidate;
                    valid_q   <= 1'b1;
                    changed_q <= diff;
                    overrun_q <= 1'b0;
                end
                EV_MERGE: begin
                    word_q    <= candidate;
                    valid_q   <= 1'b1;
                    changed_q <= changed_q | diff;
                    overrun_q <= 1'b1;
                end
                EV_ACK: begin
                    valid_q   <= 1'b0;
                    changed_q <= '0;
                    overrun_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_word    = word_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_changed = changed_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short stability window.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] changed;
        logic         overrun;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_ar  = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    switch_debounce_if #(.WIDTH(W)) bus ();

    switch_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (SIM_STABLE_CYCLES),
        .CNT_W         (DEF_CNT_W)
    ) dut (
        .i_clk (i_clk),
        .i_ar  (i_ar),
        .bus   (bus)
    );

    // 100 MHz free-running clock
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_event(input logic [W-1:0] word, input logic [W-1:0] changed,
                                input logic overrun);
        exp_t e;
        e.word    = word;
        e.changed = changed;
        e.overrun = overrun;
        sb.push_back(e);
    endtask

    task automatic check_event(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"},   32'(bus.o_valid),   32'd1);
            check({tag, "_word"},    32'(bus.o_word),    32'(e.word));
            check({tag, "_changed"}, 32'(bus.o_changed), 32'(e.changed));
            check({tag, "_overrun"}, 32'(bus.o_overrun), 32'(e.overrun));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i = 0;
        while (!bus.o_valid && i < budget) begin
            step(1);
            i++;
        end
        check({tag, "_wait_valid"}, 32'(bus.o_valid), 32'd1);
    endtask

    task automatic wait_word(input string tag, input logic [W-1:0] prev, input int budget);
        int i = 0;
        while (bus.o_word === prev && i < budget) begin
            step(1);
            i++;
        end
        check({tag, "_wait_word"}, 32'(bus.o_word !== prev), 32'd1);
    endtask

    task automatic do_ack(input string tag);
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        check({tag, "_ack_valid"},   32'(bus.o_valid),   32'd0);
        check({tag, "_ack_changed"}, 32'(bus.o_changed), 32'd0);
        check({tag, "_ack_overrun"}, 32'(bus.o_overrun), 32'd0);
    endtask

    task automatic pulse(input logic [W-1:0] val, input int n);
        bus.i_switches = val;
        step(n);
        bus.i_switches = '0;
    endtask

    // Directed sequence; expected events go into sb when stimulus is driven
    initial begin
        bus.i_switches = '0;
        bus.i_ack      = 1'b0;
        #1;
        check("rst_word",    32'(bus.o_word),    32'd0);
        check("rst_valid",   32'(bus.o_valid),   32'd0);
        check("rst_changed", 32'(bus.o_changed), 32'd0);
        check("rst_overrun", 32'(bus.o_overrun), 32'd0);
        step(2);
        i_ar = 1'b0;
        step(3);

        // Clean change with exact latency: first capture edge E, event after E+10
        bus.i_switches = 6'h05;
        expect_event(6'h05, 6'h05, 1'b0);
        step(10);
        check("clean_early_valid", 32'(bus.o_valid), 32'd0);
        check("clean_early_word",  32'(bus.o_word),  32'd0);
        step(1);
        check_event("clean");
        do_ack("clean");
        check("clean_word_held", 32'(bus.o_word), 32'h05);

        // Return to zero
        bus.i_switches = 6'h00;
        expect_event(6'h00, 6'h05, 1'b0);
        wait_valid("zero", 30);
        check_event("zero");
        do_ack("zero");

        // Short glitches are rejected
        pulse(6'h01, 5);
        step(20);
        check("glitch5_valid", 32'(bus.o_valid), 32'd0);
        check("glitch5_word",  32'(bus.o_word),  32'd0);
        pulse(6'h01, 7);
        step(20);
        check("glitch7_valid", 32'(bus.o_valid), 32'd0);
        check("glitch7_word",  32'(bus.o_word),  32'd0);

        // A 9-cycle pulse commits, then the return to zero commits as well
        expect_event(6'h01, 6'h01, 1'b0);
        pulse(6'h01, 9);
        wait_valid("pulse9", 20);
        check_event("pulse9");
        do_ack("pulse9");
        expect_event(6'h00, 6'h01, 1'b0);
        wait_valid("pulse9_back", 30);
        check_event("pulse9_back");
        do_ack("pulse9_back");

        // Overrun: second commit while the first is still pending
        bus.i_switches = 6'h05;
        expect_event(6'h05, 6'h05, 1'b0);
        wait_valid("ovr_first", 30);
        check_event("ovr_first");
        bus.i_switches = 6'h07;
        expect_event(6'h07, 6'h07, 1'b1);
        wait_word("ovr_second", 6'h05, 30);
        check_event("ovr_second");
        do_ack("ovr");

        // Ack landing on the commit edge keeps only the new mask
        bus.i_switches = 6'h05;
        expect_event(6'h05, 6'h02, 1'b0);
        wait_valid("sim_first", 30);
        check_event("sim_first");
        bus.i_switches = 6'h04;
        step(10);
        check("sim_pre_word", 32'(bus.o_word), 32'h05);
        bus.i_ack = 1'b1;
        expect_event(6'h04, 6'h01, 1'b0);
        step(1);
        bus.i_ack = 1'b0;
        check_event("sim_commit");
        do_ack("sim");

        // Bounce that settles on the committed word is silent
        for (int k = 0; k < 4; k++) begin
            bus.i_switches = 6'h06;
            step(3);
            bus.i_switches = 6'h04;
            step(3);
        end
        step(20);
        check("bounce_valid", 32'(bus.o_valid), 32'd0);
        check("bounce_word",  32'(bus.o_word),  32'h04);
        check("bounce_cnt",   32'(dut.cnt),     32'd7);

        // Asynchronous reset with an event pending and a count in progress
        bus.i_switches = 6'h03;
        expect_event(6'h03, 6'h07, 1'b0);
        wait_valid("pre_rst", 30);
        check_event("pre_rst");
        bus.i_switches = 6'h00;
        step(3);
        #2;
        i_ar = 1'b1;
        #1;
        check("arst_word",    32'(bus.o_word),    32'd0);
        check("arst_valid",   32'(bus.o_valid),   32'd0);
        check("arst_changed", 32'(bus.o_changed), 32'd0);
        check("arst_overrun", 32'(bus.o_overrun), 32'd0);
        check("arst_cnt",     32'(dut.cnt),       32'd0);
        step(2);
        i_ar = 1'b0;
        step(20);
        check("post_rst_idle", 32'(bus.o_valid), 32'd0);

        // Normal event with full latency after reset
        bus.i_switches = 6'h03;
        expect_event(6'h03, 6'h03, 1'b0);
        step(10);
        check("post_rst_early", 32'(bus.o_valid), 32'd0);
        step(1);
        check_event("post_rst");
        do_ack("post_rst");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
